// File: rtl/dmem_bus_arbiter.sv
// Arbitrates the single data-memory port between the CPU load/store path and a DMA requester.
// Each access runs IDLE -> ISSUE -> RESP; the CPU has priority, and the DMA's wait is bounded.
module dmem_bus_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          r_state, w_state_d;
  logic            r_owner;  // 1 = DMA
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [CW-1:0]   r_wait_cnt;
  logic [DW-1:0]   r_cpu_rdata, r_dma_rdata;

  logic            w_any_req, w_grant_dma, w_issue, w_resp;

  assign w_any_req   = cpu_req | dma_req;
  assign w_grant_dma = dma_req & (~cpu_req | (r_wait_cnt == CW'(MAX_WAIT)));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_d = StIssue;
      StIssue: w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && w_any_req) begin
        r_owner <= w_grant_dma;
        r_wr    <= w_grant_dma ? dma_wr    : cpu_wr;
        r_addr  <= w_grant_dma ? dma_addr  : cpu_addr;
        r_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
        if (w_grant_dma) begin
          r_wait_cnt <= '0;
        end else if (dma_req && r_wait_cnt != CW'(MAX_WAIT)) begin
          r_wait_cnt <= r_wait_cnt + CW'(1);
        end
      end
      if (r_state == StResp && !r_wr) begin
        if (r_owner) r_dma_rdata <= mem_rdata;
        else         r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign w_issue = (r_state == StIssue);
  // Strobes and acks are gated by reset so an access caught by reset is dropped silently.
  assign w_resp  = reset & (r_state == StResp);

  assign mem_rd    = reset & w_issue & ~r_wr;
  assign mem_wr    = reset & w_issue & r_wr;
  assign mem_addr  = w_issue ? r_addr  : '0;
  assign mem_wdata = w_issue ? r_wdata : '0;

  assign cpu_ack   = w_resp & ~r_owner;
  assign dma_ack   = w_resp & r_owner;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Memory data arrives during RESP; forward it alongside ack, then hold the captured copy.
  assign cpu_rdata = (cpu_ack && !r_wr) ? mem_rdata : r_cpu_rdata;
  assign dma_rdata = (dma_ack && !r_wr) ? mem_rdata : r_dma_rdata;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a vector table of single accesses plus hand-written
// sequences for reset, starvation, back-to-back and reset-in-flight.
module tb_dmem_bus_arbiter;

  logic        clk, reset;
  logic        cpu_req, cpu_wr, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_wr, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_bus_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory model; preload happens while preload is high.
  logic        preload;
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
      if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        creq, cwr;
    logic [31:0] caddr, cwdata;
    logic        dreq, dwr;
    logic [31:0] daddr, dwdata;
    logic        e_dma, e_wr;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] exp_cpu_rd, exp_dma_rd;
  int          ack_own [10];
  int          ack_cyc [10];
  int          n_acks;

  initial begin
    // creq cwr caddr cwdata | dreq dwr daddr dwdata | e_dma e_wr e_addr e_wdata e_rdata
    vecs[0] = '{1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,  0, 0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h55, 1, 1, 32'h20, 32'h55,       32'h0};
    vecs[2] = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h20, 32'h0,  1, 0, 32'h20, 32'h0,        32'h55};
    vecs[3] = '{1, 1, 32'h30, 32'h12345678, 0, 0, 32'h0,  32'h0,  0, 1, 32'h30, 32'h12345678, 32'h0};
    vecs[4] = '{1, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,  0, 0, 32'h30, 32'h0,        32'h12345678};
    vecs[5] = '{1, 0, 32'h13, 32'h0,        0, 0, 32'h0,  32'h0,  0, 0, 32'h13, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{1, 0, 32'h10, 32'h0,        1, 0, 32'h30, 32'h0,  0, 0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{0, 0, 32'h0,  32'h0,        1, 1, 32'h3C, 32'hA5, 1, 1, 32'h3C, 32'hA5,       32'h0};
    vecs[8] = '{1, 1, 32'h04, 32'h99,       1, 0, 32'h20, 32'h0,  0, 1, 32'h04, 32'h99,       32'h0};
    vecs[9] = '{0, 0, 32'h0,  32'h0,        1, 0, 32'h3C, 32'h0,  1, 0, 32'h3C, 32'h0,        32'hA5};

    preload = 1'b1;
    reset   = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h30; dma_wdata = 32'h0;

    // Reset held two cycles with both requests high
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("rst%0d mem_rd", c), 32'(mem_rd), 32'd0);
      chk($sformatf("rst%0d mem_wr", c), 32'(mem_wr), 32'd0);
      chk($sformatf("rst%0d acks", c), {30'd0, cpu_ack, dma_ack}, 32'd0);
      chk($sformatf("rst%0d cpu_rdata", c), cpu_rdata, 32'd0);
      chk($sformatf("rst%0d dma_rdata", c), dma_rdata, 32'd0);
    end
    @(posedge clk); #1 reset = 1'b1; preload = 1'b0;
    @(negedge clk);
    chk("rel stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rel mem_rd", 32'(mem_rd), 32'd1);
    chk("rel mem_addr", mem_addr, 32'h10);
    @(posedge clk); @(negedge clk);
    chk("rel cpu_ack", 32'(cpu_ack), 32'd1);
    chk("rel dma_ack", 32'(dma_ack), 32'd0);
    chk("rel cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;
    exp_cpu_rd = 32'hDEADBEEF;
    exp_dma_rd = 32'h0;

    // Vector table: one access each, separated by an idle cycle
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cpu_req = vecs[i].creq; cpu_wr = vecs[i].cwr;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      dma_req = vecs[i].dreq; dma_wr = vecs[i].dwr;
      dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwdata;
      @(negedge clk);
      chk($sformatf("v%0d stall_n", i), 32'(cpu_stall), 32'(vecs[i].creq));
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d mem_rd", i), 32'(mem_rd), 32'(!vecs[i].e_wr));
      chk($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d early_ack", i), {30'd0, cpu_ack, dma_ack}, 32'd0);
      if (!vecs[i].e_wr) begin
        if (vecs[i].e_dma) exp_dma_rd = vecs[i].e_rdata;
        else               exp_cpu_rd = vecs[i].e_rdata;
      end
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d cpu_ack", i), 32'(cpu_ack), 32'(!vecs[i].e_dma));
      chk($sformatf("v%0d dma_ack", i), 32'(dma_ack), 32'(vecs[i].e_dma));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, exp_cpu_rd);
      chk($sformatf("v%0d dma_rdata", i), dma_rdata, exp_dma_rd);
      chk($sformatf("v%0d mem_idle", i), {30'd0, mem_rd, mem_wr}, 32'd0);
      chk($sformatf("v%0d stall_r", i), 32'(cpu_stall), 32'(vecs[i].creq && vecs[i].e_dma));
      @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;
    end

    // Starvation: both requesting continuously, expect C,C,C,C,D twice
    for (int k = 0; k < 10; k++) begin ack_own[k] = -1; ack_cyc[k] = -1; end
    n_acks = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h3C;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (cpu_ack && dma_ack) chk($sformatf("starv both acks c%0d", c), 32'd1, 32'd0);
      else if (cpu_ack || dma_ack) begin
        if (n_acks < 10) begin
          ack_own[n_acks] = dma_ack ? 1 : 0;
          ack_cyc[n_acks] = c;
        end
        n_acks++;
      end
      if (c < 29) @(posedge clk);
    end
    @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;
    chk("starv n_acks", 32'(n_acks), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starv own%0d", k), 32'(ack_own[k]), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starv cyc%0d", k), 32'(ack_cyc[k]), 32'(2 + 3 * k));
    end

    // Back-to-back CPU reads with req held across acks
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("b2b mem_rd c%0d", c), 32'(mem_rd), 32'(c % 3 == 1));
      chk($sformatf("b2b cpu_ack c%0d", c), 32'(cpu_ack), 32'(c % 3 == 2));
      chk($sformatf("b2b dma_ack c%0d", c), 32'(dma_ack), 32'd0);
      if (c < 8) @(posedge clk);
    end
    chk("b2b cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    @(posedge clk); #1 cpu_req = 1'b0;

    // Reset during ISSUE of a CPU write: strobe suppressed, no ack, memory untouched
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h3C; cpu_wdata = 32'h77;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst cpu_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1 reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("midrst ack_after", {30'd0, cpu_ack, dma_ack}, 32'd0);
    chk("midrst strobes_after", {30'd0, mem_rd, mem_wr}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("midrst ack_late", 32'(cpu_ack), 32'd0);
    chk("midrst mem15", mem[15], 32'hA5);
    chk("midrst cpu_rdata", cpu_rdata, 32'd0);
    // Fresh access after reset proves the FSM is back in IDLE
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h30;
    @(posedge clk); @(negedge clk);
    chk("post mem_rd", 32'(mem_rd), 32'd1);
    chk("post mem_addr", mem_addr, 32'h30);
    @(posedge clk); @(negedge clk);
    chk("post cpu_ack", 32'(cpu_ack), 32'd1);
    chk("post cpu_rdata", cpu_rdata, 32'h12345678);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
